// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic, S-box, MixColumns column, Rcon and FSM states.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} aes_st_e;

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic int aes_nr(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xtime(x);
    end
    return r;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0), then the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p, v;
    p = a;
    v = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      v = gmul(v, p);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round_dp.sv
// One combinational AES encryption round; `last` drops MixColumns for the final round.
module aes_round_dp
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] nxt
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [31:0] sub_col;
    // ShiftRows: row r of output column c comes from input column (c+r)%4.
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sub_col[31-8*r -: 8] = sbox(st[127 - 8*(4*((c+r)%4) + r) -: 8]);
    end
    assign nxt[127-32*c -: 32] = (last ? sub_col : mixcol(sub_col)) ^ rk[127-32*c -: 32];
  end

endmodule

// File: rtl/aes_iter_engine.sv
// Iterative AES encryptor: one round per clock, stored key schedule reusable across blocks.
module aes_iter_engine
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_BITS-1:0] anahtar,
  input  logic                anahtar_yeni,
  input  logic [127:0]        blok,
  input  logic                g_gecerli,
  output logic                hazir,
  output logic [127:0]        sifre,
  output logic                c_gecerli,
  input  logic                c_hazir
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = aes_nr(KEY_BITS);
  localparam int NW = 4 * (NR + 1);
  localparam int KW = NW - NK;

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key
    $error("aes_iter_engine: KEY_BITS must be 128, 192 or 256");
  end

  aes_st_e             state, state_nxt;
  logic [NW-1:0][31:0] sched;
  logic [127:0]        st, rk0, rk, dp_out;
  logic                sched_ok, new_key, last;
  logic [3:0]          rnd;
  logic [5:0]          wcnt, rk_base, i_mod, i_div;
  logic [31:0]         w_prev, w_old, w_t;

  assign hazir     = (state == IDLE);
  assign c_gecerli = (state == DONE);
  assign new_key   = anahtar_yeni | ~sched_ok;
  assign rk0       = new_key ? anahtar[KEY_BITS-1 -: 128]
                             : {sched[0], sched[1], sched[2], sched[3]};
  assign rk_base   = {rnd, 2'b00};
  assign rk        = {sched[rk_base], sched[rk_base + 6'd1],
                      sched[rk_base + 6'd2], sched[rk_base + 6'd3]};
  assign last      = (rnd == 4'(NR));

  aes_round_dp u_dp (.st(st), .rk(rk), .last(last), .nxt(dp_out));

  // Key expansion word generator for schedule index wcnt.
  assign w_prev = sched[wcnt - 6'd1];
  assign w_old  = sched[wcnt - 6'(NK)];
  assign i_mod  = wcnt % 6'(NK);
  assign i_div  = wcnt / 6'(NK);

  always_comb begin
    w_t = w_prev;
    if (i_mod == 6'd0)
      w_t = subword({w_prev[23:0], w_prev[31:24]}) ^ {RCON[4'(i_div - 6'd1)], 24'h0};
    else if (NK == 8 && i_mod == 6'd4)
      w_t = subword(w_prev);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (g_gecerli) state_nxt = new_key ? KEXP : ROUND;
      KEXP:    if (wcnt == 6'(NK + KW - 1)) state_nxt = ROUND;
      ROUND:   if (last) state_nxt = DONE;
      DONE:    if (c_hazir) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sifre    <= '0;
      sched_ok <= 1'b0;
      rnd      <= '0;
      wcnt     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (g_gecerli) begin
          rnd <= 4'd1;
          if (new_key) begin
            sched_ok <= 1'b0;
            wcnt     <= 6'(NK);
          end
        end
        KEXP: begin
          wcnt <= wcnt + 6'd1;
          if (wcnt == 6'(NK + KW - 1)) sched_ok <= 1'b1;
        end
        ROUND: begin
          rnd <= rnd + 4'd1;
          if (last) sifre <= dp_out;
        end
        default: ;
      endcase
    end
  end

  // Datapath storage needs no reset; validity is tracked by state and sched_ok.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && g_gecerli) begin
        st <= blok ^ rk0;
        if (new_key)
          for (int j = 0; j < NK; j++) sched[j] <= anahtar[KEY_BITS-1-32*j -: 32];
      end else if (state == KEXP) begin
        sched[wcnt] <= w_old ^ w_t;
      end else if (state == ROUND) begin
        st <= dp_out;
      end
    end
  end

endmodule

// File: tb/tb_aes_iter_engine.sv
// Bench for aes_iter_engine at 128/192/256-bit keys against a byte-level AES reference model.
module tb_aes_iter_engine;

  logic         clk, rst;
  logic [255:0] key_v   [3];
  logic         yeni_v  [3];
  logic [127:0] blok_v  [3];
  logic         g_v     [3];
  logic         hazir_v [3];
  logic [127:0] sifre_v [3];
  logic         cg_v    [3];
  logic         ch_v    [3];

  int errors = 0, checks = 0, cyc = 0;
  logic [7:0]   sb_tab [256];
  logic [255:0] skey   [3];
  logic         sk_valid [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int KB = 128 + 64 * gi;
    aes_iter_engine #(.KEY_BITS(KB)) u_dut (
      .clk(clk), .rst(rst), .anahtar(key_v[gi][KB-1:0]), .anahtar_yeni(yeni_v[gi]),
      .blok(blok_v[gi]), .g_gecerli(g_v[gi]), .hazir(hazir_v[gi]), .sifre(sifre_v[gi]),
      .c_gecerli(cg_v[gi]), .c_hazir(ch_v[gi]));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int rol8(input int v, input int n);
    return ((v << n) | (v >> (8 - n))) & 8'hff;
  endfunction

  // S-box from walking the multiplicative group with generator 3 and its inverse.
  task automatic build_sbox();
    int p, q, x;
    p = 1; q = 1;
    do begin
      p = (p ^ (p << 1) ^ (((p & 8'h80) != 0) ? 8'h1b : 0)) & 8'hff;
      q = q ^ (q << 1); q = q ^ (q << 2); q = q ^ (q << 4); q = q & 8'hff;
      if ((q & 8'h80) != 0) q = q ^ 8'h09;
      x = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4);
      sb_tab[p] = 8'(x ^ 8'h63);
    end while (p != 1);
    sb_tab[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_ref(input logic [255:0] key, input int nk, input logic [127:0] pt);
    logic [7:0] w [60][4];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3, rc;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++)
      for (int r = 0; r < 4; r++) w[i][r] = key[255 - 32*i - 8*r -: 8];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      a0 = w[i-1][0]; a1 = w[i-1][1]; a2 = w[i-1][2]; a3 = w[i-1][3];
      if (i % nk == 0) begin
        {a0, a1, a2, a3} = {sb_tab[a1] ^ rc, sb_tab[a2], sb_tab[a3], sb_tab[a0]};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        {a0, a1, a2, a3} = {sb_tab[a0], sb_tab[a1], sb_tab[a2], sb_tab[a3]};
      end
      w[i][0] = w[i-nk][0] ^ a0; w[i][1] = w[i-nk][1] ^ a1;
      w[i][2] = w[i-nk][2] ^ a2; w[i][3] = w[i-nk][3] ^ a3;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127 - 8*b -: 8] ^ w[b/4][b%4];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int b = 0; b < 16; b++) t[b] = sb_tab[s[(b%4) + 4*(((b/4) + (b%4)) % 4)]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rnd < nr)
            s[4*c+r] = xt(t[4*c+r]) ^ xt(t[4*c+(r+1)%4]) ^ t[4*c+(r+1)%4]
                       ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
          else
            s[4*c+r] = t[4*c+r];
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*rnd + b/4][b%4];
    end
    for (int b = 0; b < 16; b++) res[127 - 8*b -: 8] = s[b];
    return res;
  endfunction

  // Tracks which key each instance's stored schedule belongs to.
  task automatic model_step(input int k, input logic [255:0] key, input logic yeni,
                            input logic [127:0] pt, output logic [127:0] ect, output int elat);
    int nk, nr;
    logic fresh;
    nk = 4 + 2*k; nr = nk + 6;
    fresh = yeni | ~sk_valid[k];
    if (fresh) begin skey[k] = key; sk_valid[k] = 1'b1; end
    ect  = aes_ref(skey[k], nk, pt);
    elat = fresh ? (4*(nr+1) - nk + nr + 1) : (nr + 1);
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver ----------------
  // Called #1 after an edge. Latency counts the accept edge and the c_gecerli rise edge inclusively.
  task automatic run_block(input int k, input logic [255:0] key, input logic yeni, input logic [127:0] pt,
                           output logic [127:0] ct, output int lat, output int rise);
    int n;
    n = 0;
    while (hazir_v[k] !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    key_v[k] = key >> (256 - (128 + 64*k));
    yeni_v[k] = yeni; blok_v[k] = pt; g_v[k] = 1'b1;
    @(posedge clk); #1;
    g_v[k] = 1'b0; key_v[k] = rnd256(); blok_v[k] = rnd128(); yeni_v[k] = 1'($urandom);
    lat = 1;
    while (cg_v[k] !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    ct = sifre_v[k];
    rise = cyc;
    if (cg_v[k] !== 1'b1) begin
      errors++; checks++;
      $display("FAIL timeout inst%0d: c_gecerli=%b required 1 within 200 cycles", k, cg_v[k]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) sk_valid[k] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    for (int k = 0; k < 3; k++) begin
      checks += 3;
      if (hazir_v[k] !== 1'b1) begin errors++; $display("FAIL reset_hazir inst%0d: got %b want 1", k, hazir_v[k]); end
      if (cg_v[k] !== 1'b0) begin errors++; $display("FAIL reset_cg inst%0d: got %b want 0", k, cg_v[k]); end
      if (sifre_v[k] !== 128'h0) begin errors++; $display("FAIL reset_sifre inst%0d: got %h want 0", k, sifre_v[k]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_kat128();
    logic [127:0] ct, ect; int lat, elat, rise;
    logic [255:0] key;
    key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    model_step(0, key, 1'b1, 128'h3243f6a8885a308d313198a2e0370734, ect, elat);
    run_block(0, key, 1'b1, 128'h3243f6a8885a308d313198a2e0370734, ct, lat, rise);
    checks += 2;
    if (ct !== 128'h3925841d02dc09fbdc118597196a0b32) begin errors++; $display("FAIL kat128_ct: got %h want 3925841d02dc09fbdc118597196a0b32", ct); end
    if (lat !== 51) begin errors++; $display("FAIL kat128_lat: got %0d want 51", lat); end
  endtask

  task automatic test_key_reuse();
    logic [127:0] ct, ect; int lat, elat, rise;
    logic [255:0] key;
    key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    model_step(0, key, 1'b1, 128'h00112233445566778899aabbccddeeff, ect, elat);
    run_block(0, key, 1'b1, 128'h00112233445566778899aabbccddeeff, ct, lat, rise);
    checks += 2;
    if (ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin errors++; $display("FAIL fips128_ct: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", ct); end
    if (lat !== 51) begin errors++; $display("FAIL fips128_lat: got %0d want 51", lat); end
    // A different key presented with anahtar_yeni=0 must not disturb the stored schedule.
    model_step(0, key, 1'b0, 128'h00112233445566778899aabbccddeeff, ect, elat);
    run_block(0, rnd256(), 1'b0, 128'h00112233445566778899aabbccddeeff, ct, lat, rise);
    checks += 2;
    if (ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin errors++; $display("FAIL reuse_ct: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", ct); end
    if (lat !== 11) begin errors++; $display("FAIL reuse_lat: got %0d want 11", lat); end
  endtask

  task automatic test_kat_wide();
    logic [127:0] ct, ect; int lat, elat, rise;
    logic [255:0] key;
    key = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    model_step(1, key, 1'b1, 128'h00112233445566778899aabbccddeeff, ect, elat);
    run_block(1, key, 1'b1, 128'h00112233445566778899aabbccddeeff, ct, lat, rise);
    checks += 2;
    if (ct !== 128'hdda97ca4864cdfe06eaf70a0ec0d7191) begin errors++; $display("FAIL kat192_ct: got %h want dda97ca4864cdfe06eaf70a0ec0d7191", ct); end
    if (lat !== 59) begin errors++; $display("FAIL kat192_lat: got %0d want 59", lat); end
    key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    model_step(2, key, 1'b1, 128'h00112233445566778899aabbccddeeff, ect, elat);
    run_block(2, key, 1'b1, 128'h00112233445566778899aabbccddeeff, ct, lat, rise);
    checks += 2;
    if (ct !== 128'h8ea2b7ca516745bfeafc49904b496089) begin errors++; $display("FAIL kat256_ct: got %h want 8ea2b7ca516745bfeafc49904b496089", ct); end
    if (lat !== 67) begin errors++; $display("FAIL kat256_lat: got %0d want 67", lat); end
  endtask

  task automatic test_random();
    logic [127:0] ct, ect, pt; int lat, elat, rise, k;
    logic [255:0] key; logic yeni;
    for (int it = 0; it < 24; it++) begin
      k = (it < 16) ? 0 : 1 + (it % 2);
      key = rnd256(); pt = rnd128(); yeni = ($urandom_range(0, 2) == 0);
      model_step(k, key, yeni, pt, ect, elat);
      run_block(k, key, yeni, pt, ct, lat, rise);
      checks += 2;
      if (ct !== ect) begin errors++; $display("FAIL rand_ct inst%0d it%0d: got %h want %h", k, it, ct, ect); end
      if (lat !== elat) begin errors++; $display("FAIL rand_lat inst%0d it%0d: got %0d want %0d", k, it, lat, elat); end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] ct, ect, ct2, ect2, pt2; int lat, elat, rise;
    logic [255:0] key;
    key = rnd256(); pt2 = rnd128();
    ch_v[0] = 1'b0;
    model_step(0, key, 1'b1, 128'h0f0e0d0c0b0a09080706050403020100, ect, elat);
    run_block(0, key, 1'b1, 128'h0f0e0d0c0b0a09080706050403020100, ct, lat, rise);
    checks++;
    if (ct !== ect) begin errors++; $display("FAIL bp_ct: got %h want %h", ct, ect); end
    key_v[0] = '0; yeni_v[0] = 1'b0; blok_v[0] = pt2; g_v[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (sifre_v[0] !== ect || cg_v[0] !== 1'b1 || hazir_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: sifre=%h cg=%b hazir=%b want %h 1 0", i, sifre_v[0], cg_v[0], hazir_v[0], ect);
      end
    end
    ch_v[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (hazir_v[0] !== 1'b1 || cg_v[0] !== 1'b0) begin
      errors++; $display("FAIL bp_release: hazir=%b cg=%b want 1 0", hazir_v[0], cg_v[0]);
    end
    model_step(0, key, 1'b0, pt2, ect2, elat);
    run_block(0, rnd256(), 1'b0, pt2, ct2, lat, rise);
    checks += 2;
    if (ct2 !== ect2) begin errors++; $display("FAIL bp_next_ct: got %h want %h", ct2, ect2); end
    if (lat !== 11) begin errors++; $display("FAIL bp_next_lat: got %0d want 11", lat); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ct, ect, pt; int lat, elat, rise, prev;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      pt = rnd128();
      model_step(0, '0, 1'b0, pt, ect, elat);
      run_block(0, '0, 1'b0, pt, ct, lat, rise);
      checks++;
      if (ct !== ect) begin errors++; $display("FAIL b2b_ct blk%0d: got %h want %h", i, ct, ect); end
      if (i > 0) begin
        checks++;
        if (rise - prev !== 12) begin errors++; $display("FAIL b2b_period blk%0d: got %0d want 12", i, rise - prev); end
      end
      prev = rise;
    end
  endtask

  task automatic test_reset_kexp();
    logic [127:0] ct, ect, pt; int lat, elat, rise;
    logic [255:0] key;
    key_v[0] = rnd256() >> 128; yeni_v[0] = 1'b1; blok_v[0] = rnd128(); g_v[0] = 1'b1;
    @(posedge clk); #1;
    g_v[0] = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    do_reset();
    checks += 3;
    if (hazir_v[0] !== 1'b1) begin errors++; $display("FAIL rst_kexp_hazir: got %b want 1", hazir_v[0]); end
    if (cg_v[0] !== 1'b0) begin errors++; $display("FAIL rst_kexp_cg: got %b want 0", cg_v[0]); end
    if (sifre_v[0] !== 128'h0) begin errors++; $display("FAIL rst_kexp_sifre: got %h want 0", sifre_v[0]); end
    key = rnd256(); pt = rnd128();
    model_step(0, key, 1'b0, pt, ect, elat);
    run_block(0, key, 1'b0, pt, ct, lat, rise);
    checks += 2;
    if (ct !== ect) begin errors++; $display("FAIL rst_kexp_ct: got %h want %h", ct, ect); end
    if (lat !== 51) begin errors++; $display("FAIL rst_kexp_lat: got %0d want 51", lat); end
  endtask

  task automatic test_reset_round();
    logic [127:0] ct, ect, pt; int lat, elat, rise;
    logic [255:0] key;
    yeni_v[0] = 1'b0; blok_v[0] = rnd128(); g_v[0] = 1'b1;
    @(posedge clk); #1;
    g_v[0] = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    do_reset();
    checks += 2;
    if (hazir_v[0] !== 1'b1) begin errors++; $display("FAIL rst_round_hazir: got %b want 1", hazir_v[0]); end
    if (cg_v[0] !== 1'b0) begin errors++; $display("FAIL rst_round_cg: got %b want 0", cg_v[0]); end
    key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}; pt = 128'h3243f6a8885a308d313198a2e0370734;
    model_step(0, key, 1'b1, pt, ect, elat);
    run_block(0, key, 1'b1, pt, ct, lat, rise);
    checks += 2;
    if (ct !== 128'h3925841d02dc09fbdc118597196a0b32) begin errors++; $display("FAIL rst_round_ct: got %h want 3925841d02dc09fbdc118597196a0b32", ct); end
    if (lat !== elat) begin errors++; $display("FAIL rst_round_lat: got %0d want %0d", lat, elat); end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      key_v[k] = '0; yeni_v[k] = 1'b0; blok_v[k] = '0; g_v[k] = 1'b0; ch_v[k] = 1'b1;
      sk_valid[k] = 1'b0; skey[k] = '0;
    end
    build_sbox();
    test_reset();
    test_kat128();
    test_key_reuse();
    test_kat_wide();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_kexp();
    test_reset_round();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_iter_engine.md
# aes_iter_engine

Parametrised, iterative AES encryption engine: one round per clock, key length selectable at elaboration (128/192/256). Replaces the fully unrolled 128-bit engine. Area drops to a single round datapath plus a stored key schedule, and the block gains a real valid/ready handshake on both sides and key-schedule reuse across blocks. It sits between the block source (`g_*` side) and the ciphertext consumer (`c_*` side).

## Interface
- `KEY_BITS`, default 128: key length; legal values are 128, 192, 256. Any other value is an elaboration error.
  - Derived: `NK = KEY_BITS/32`, `NR = NK+6`, `KW = 4*(NR+1) - NK` (generated schedule words: 40, 46 or 52).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `anahtar`  in  KEY_BITS  cipher key. Bits [KEY_BITS-1 -: 32] are w0.
- `anahtar_yeni`  in  1  sampled at accept. 1 = expand `anahtar`; 0 = reuse the stored schedule.
- `blok`  in  128  plaintext. Bit 127 is byte 0 (FIPS-197 column-major order).
- `g_gecerli`  in  1  input valid.
- `hazir`  out  1  engine can accept an input.
- `sifre`  out  128  ciphertext. Registered; held stable while `c_gecerli`=1.
- `c_gecerli`  out  1  ciphertext valid.
- `c_hazir`  in  1  consumer ready.

## Operation
- FSM states: IDLE, KEXP, ROUND, DONE.
- Accept: `g_gecerli & hazir` at a rising edge. `hazir` = (state==IDLE).
  - At accept, latch the key and the effective new-key flag.
  - `st <= blok ^ (w0..w3)`. w0..w3 come from `anahtar` if the key is new, otherwise from the stored schedule.
- Effective new-key flag = `anahtar_yeni | ~sched_ok`. After reset the first block always expands.
- Next state after IDLE: KEXP if the key is new, else ROUND with `rnd=1`.
- KEXP:
  - Generate one schedule word per cycle, i = NK .. 4*(NR+1)-1, using `w[i] = w[i-NK] ^ t`.
  - t = SubWord(RotWord(w[i-1])) ^ Rcon[i/NK] when i%NK==0.
  - t = SubWord(w[i-1]) when NK==8 and i%NK==4.
  - Otherwise t = w[i-1].
  - Words 0..NK-1 are loaded from the key at accept.
  - After KW cycles: set `sched_ok`=1 and go to ROUND, `rnd=1`.
- ROUND, one cycle per round:
  - `st <= MixColumns(ShiftRows(SubBytes(st))) ^ rk[rnd]`.
  - At `rnd==NR`, MixColumns is omitted, `sifre <= result`, and the FSM goes to DONE.
- DONE: `c_gecerli`=1. On `c_hazir`=1, clear `c_gecerli` and return to IDLE.
- Arithmetic is GF(2^8) with polynomial 0x11B. No carries, no widths beyond 128/32/8.

## Timing
- Reset values: `hazir`=1 (state IDLE), `c_gecerli`=0, `sifre`=0, `sched_ok`=0. Round counter and word counter are 0.
- While `rst`=1, all inputs are ignored.
- Reset mid-operation (any state) aborts the operation. The next cycle is IDLE, with no output and the schedule invalidated.
- Latency is counted from the accept edge to the edge at which `c_gecerli` rises:
  - Reused key: NR+1 edges (11/13/15).
  - New key: KW+NR+1 edges (51/59/67).
- Back-to-back transfers:
  - `hazir` returns to 1 in the cycle after the DONE→IDLE handshake edge. There is no accept in the same cycle as the output handshake.
  - Throughput with a reused key is one block per NR+2 cycles when `c_hazir` is held at 1.
- Backpressure: `c_hazir`=0 holds DONE indefinitely. `sifre` and `c_gecerli` stay stable; `hazir` stays 0.
- `anahtar` and `blok` are sampled only at the accept edge. Changes afterward have no effect.
- `anahtar_yeni`=0 with `sched_ok`=1 and a different `anahtar` value: the stored schedule is used (caller responsibility).

## Structure
- `aes_pkg`, shared package:
  - `sbox` function.
  - `xtime` and `mixcol` functions.
  - Rcon constant array (10 entries).
  - `aes_nr(KEY_BITS)` function.
  - State enum `aes_st_e`.
- One sub-module: `aes_round_dp`, combinational, input `st`, round key and a `last` flag; output is the next state.
  - It is also reused by the future decrypt variant.
- The schedule is a register array of 4*(NR+1) 32-bit words. The word generator stays inline in the top module.

## Test plan
- AES-128: key 2b7e151628aed2a6abf7158809cf4f3c, `anahtar_yeni`=1, `blok` 3243f6a8885a308d313198a2e0370734 → `sifre` 3925841d02dc09fbdc118597196a0b32; `c_gecerli` rises 51 edges after accept.
- AES-128: key 000102…0f, pt 00112233…eeff → 69c4e0d86a7b0430d8cdb78070b4c55a. Then send the same pt with `anahtar_yeni`=0 → same ct at latency 11.
- KEY_BITS=192: key 000102…17 → dda97ca4864cdfe06eaf70a0ec0d7191 (latency 59). KEY_BITS=256: key 000102…1f → 8ea2b7ca516745bfeafc49904b496089 (latency 67).
- Hold `c_hazir`=0 for 20 cycles in DONE → `sifre` and `c_gecerli` stable and `hazir`=0. A new `g_gecerli` is ignored until one cycle after the handshake.
- Assert `rst` in KEXP cycle 10 → `hazir`=1, `c_gecerli`=0 next cycle. The next block with `anahtar_yeni`=0 still expands (latency 51 at 128).
- Apply `rst` mid-ROUND, then accept a new block → the output matches the reference vector with no residue of the aborted block.
